apb_trig_seq_master: RTL and testbench
======================================

Name: apb_trig_seq_master

Overview:
- APB initiator that executes a programmed sequence of APB register writes each time an ETB-style trigger pulse arrives.
- It is the master-side counterpart to the timer block's APB slave and trigger outputs. A timer trigger (e.g. tim1_etb_trig) can reprogram another peripheral, such as restarting a second timer, with no CPU involvement.
- It holds a small table of (address, data) entries and issues them back-to-back over a standard APB2/3 master port.

Parameters:
DEPTH, 4, number of table entries; power of 2, range 2..16.
IW, $clog2(DEPTH), entry index width; derived, not overridden.
TIMEOUT, 16, max ACCESS cycles waiting for m_pready. Used only when the optional feature is compiled in.

Ports:
pclk  input  1  clock
presetn  input  1  asynchronous active-low reset
trig  input  1  single-cycle trigger pulse
seq_en  input  1  sequencer enable; when 0, triggers are ignored and not latched
cfg_we  input  1  table write strobe
cfg_idx  input  IW  table entry index
cfg_addr  input  32  entry APB address
cfg_data  input  32  entry APB write data
cfg_num  input  IW+1  number of entries to execute per trigger (0..DEPTH)
clr  input  1  clears sticky err and ovf
m_psel  output  1  APB select
m_penable  output  1  APB enable
m_pwrite  output  1  APB write
m_paddr  output  32  APB address
m_pwdata  output  32  APB write data
m_pready  input  1  APB ready
m_pslverr  input  1  APB slave error
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when a sequence ends, whether normal or aborted
err  output  1  sticky: transfer error
ovf  output  1  sticky: trigger lost

Behaviour:
- Reset (async, presetn=0): all outputs 0; FSM=IDLE; pending=0; table entries cleared to 0.
- All outputs are registered.
- Table writes:
  - cfg_we=1 with busy=0 writes entry cfg_idx on that edge.
  - cfg_we while busy=1 is ignored.
  - cfg_num is sampled at sequence start; values above DEPTH are clamped to DEPTH.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Start condition: (trig | pending) & seq_en & cfg_num!=0.
  - On start: idx=0, busy=1, go to SETUP, clear pending.
  - Trigger at edge N gives m_psel=1 at edge N+1.
  - trig with cfg_num==0: ignored, no done pulse.
- SETUP:
  - Outputs m_psel=1, m_penable=0, m_pwrite=1, m_paddr=addr[idx], m_pwdata=data[idx].
  - Next state is ACCESS.
- ACCESS:
  - Outputs m_psel=1, m_penable=1; addr/data stay stable.
  - m_pready=0: stay in ACCESS.
  - m_pready=1 & m_pslverr=1: set err, go to IDLE, pulse done, busy=0; remaining entries are skipped.
  - m_pready=1 & m_pslverr=0 & idx<num-1: idx+1, go to SETUP. Back-to-back, no idle cycle.
  - m_pready=1 & m_pslverr=0 & idx==num-1: go to IDLE, m_psel=0, m_penable=0, busy=0, done=1 for one cycle.
- Outside SETUP/ACCESS: m_psel=m_penable=m_pwrite=0; m_paddr and m_pwdata hold their last values.
- Trigger while busy:
  - If pending=0: set pending. The new sequence starts on the cycle after IDLE is re-entered.
  - If pending=1: set ovf; the trigger is dropped.
- A trigger arriving in the same cycle a sequence ends is latched as pending.
- seq_en deasserted mid-sequence: the current sequence completes. Pending is kept but not launched until seq_en=1.
- clr: clears err and ovf. If clr coincides with a set event in the same cycle, set wins.
- Sequence duration with zero-wait slaves: 2*num cycles from first SETUP to the done edge.

Optional Feature:
Macro: APB_TRIG_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS and is reset on entry to each ACCESS.
  - If m_pready stays 0 for TIMEOUT consecutive ACCESS cycles: drop m_psel/m_penable, set err, go to IDLE, pulse done, busy=0.
- Not defined:
  - No counter is built.
  - ACCESS waits indefinitely for m_pready.

Test Plan:
1. Basic sequence: table {0x40:0x1, 0x44:0x2, 0x48:0x3}, cfg_num=3, zero-wait slave, trig pulse -> three writes in order with psel/penable phases; busy high 6 cycles; done pulses once; err=0.
2. Wait states and error: entry 1 slave inserts 2 wait cycles, then returns pslverr=1 -> addr/data held stable through the waits; entry 2 never issued; err=1, done=1; clr -> err=0.
3. Trigger queuing: trig during sequence -> second sequence starts the cycle after IDLE; two more trigs during the second sequence -> first latched, second sets ovf=1.
4. Guard cases:
   - cfg_num=0, trig -> no APB activity, no done.
   - seq_en=0, trig -> ignored, pending stays 0.
   - cfg_we while busy -> table unchanged (verify on next trigger).
5. Reset mid-ACCESS: presetn=0 while m_penable=1 -> all outputs 0 immediately (async); after release FSM=IDLE, table zeroed.
6. With APB_TRIG_SEQ_TIMEOUT_EN: m_pready held 0 -> psel dropped after 16 ACCESS cycles; err=1, done=1.

Source files
------------

// File: rtl/apb_trig_seq_master.sv
// apb_trig_seq_master: on each trigger, replays a small table of (addr, data) APB writes.
// Optional macro APB_TRIG_SEQ_TIMEOUT_EN adds an ACCESS-phase watchdog on m_pready.
// Latency: trigger sampled at edge N puts SETUP on the bus after edge N; 2 cycles per zero-wait write.
module apb_trig_seq_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          trig,
  input  logic          seq_en,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [31:0]   cfg_addr,
  input  logic [31:0]   cfg_data,
  input  logic [IW:0]   cfg_num,
  input  logic          clr,
  output logic          m_psel,
  output logic          m_penable,
  output logic          m_pwrite,
  output logic [31:0]   m_paddr,
  output logic [31:0]   m_pwdata,
  input  logic          m_pready,
  input  logic          m_pslverr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          ovf
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("apb_trig_seq_master: unsupported DEPTH/TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [IW:0]   NUM_MAX = (IW+1)'(DEPTH);
  localparam logic [IW:0]   NUM_ONE = (IW+1)'(1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  state_t        state;
  logic [31:0]   tbl_addr [DEPTH];
  logic [31:0]   tbl_data [DEPTH];
  logic [IW-1:0] idx;
  logic [IW:0]   num;
  logic          pending;

`ifdef APB_TRIG_SEQ_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0] tmo_cnt;
`endif

  logic          start;
  logic          trig_evt;
  logic          last;
  logic [IW-1:0] idx_nxt;

  assign trig_evt = trig & seq_en;
  assign start    = (trig | pending) & seq_en & (cfg_num != '0);
  assign last     = ({1'b0, idx} == (num - NUM_ONE));
  assign idx_nxt  = idx + IDX_ONE;

  // Entry table: writable only while no sequence is running.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  // Sequencer FSM with registered APB outputs, status flags and trigger queueing.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      idx       <= '0;
      num       <= '0;
      pending   <= 1'b0;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
`ifdef APB_TRIG_SEQ_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      // clr first so that a same-cycle set below takes priority
      if (clr) begin
        err <= 1'b0;
        ovf <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= SETUP;
            idx       <= '0;
            num       <= (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
            pending   <= 1'b0;
            busy      <= 1'b1;
            m_psel    <= 1'b1;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b1;
            m_paddr   <= tbl_addr[0];
            m_pwdata  <= tbl_data[0];
          end
        end
        SETUP: begin
          state     <= ACCESS;
          m_penable <= 1'b1;
`ifdef APB_TRIG_SEQ_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        ACCESS: begin
          if (m_pready) begin
            if (m_pslverr || last) begin
              // sequence ends here; an error skips any remaining entries
              state     <= IDLE;
              m_psel    <= 1'b0;
              m_penable <= 1'b0;
              m_pwrite  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              if (m_pslverr) err <= 1'b1;
            end else begin
              state     <= SETUP;
              idx       <= idx_nxt;
              m_penable <= 1'b0;
              m_paddr   <= tbl_addr[idx_nxt];
              m_pwdata  <= tbl_data[idx_nxt];
            end
          end
`ifdef APB_TRIG_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state     <= IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
      // one trigger can be queued behind a running sequence; a second one is lost
      if (state != IDLE && trig_evt) begin
        if (pending) ovf <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_trig_seq_master.sv
// Testbench for apb_trig_seq_master: random tables, wait states and errors vs a transaction-level model.
// Expected writes come from a bench-side copy of the table; a negedge monitor acts as APB slave.
module tb_apb_trig_seq_master;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          trig = 1'b0, seq_en = 1'b0, cfg_we = 1'b0, clr = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [31:0]   cfg_addr = '0, cfg_data = '0;
  logic [IW:0]   cfg_num = '0;
  logic          m_psel, m_penable, m_pwrite;
  logic [31:0]   m_paddr, m_pwdata;
  logic          m_pready = 1'b0, m_pslverr = 1'b0;
  logic          busy, done, err, ovf;

  always #5 pclk = ~pclk;

  apb_trig_seq_master #(.DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn), .trig(trig), .seq_en(seq_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_num(cfg_num), .clr(clr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: table contents and expected / observed completed writes
  logic [31:0] mdl_addr [DEPTH];
  logic [31:0] mdl_data [DEPTH];
  logic [31:0] exp_a[$], exp_d[$], obs_a[$], obs_d[$];

  // slave behaviour per transfer (index = transfer number within the run)
  int wait_cfg [64];
  bit err_cfg [64];
  int xn = 0, wcnt = 0;

  int cyc = 0, busy_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int hold_viol = 0, pwrite_viol = 0, last_done_cyc = 0, gap = -1;
  bit prev_wait = 0, prev_psel = 0;
  logic [31:0] prev_a = '0, prev_d = '0;

  // monitor + APB slave responder, evaluated on the falling edge
  initial forever begin
    @(negedge pclk);
    cyc++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; last_done_cyc = cyc; end
    if (m_psel && !prev_psel) gap = cyc - last_done_cyc;
    prev_psel = m_psel;
    if (m_psel && !m_pwrite) pwrite_viol++;
    if (m_psel && m_penable) begin
      acc_cnt++;
      if (prev_wait && (m_paddr !== prev_a || m_pwdata !== prev_d)) hold_viol++;
      if (wcnt < wait_cfg[xn]) begin
        m_pready = 1'b0; m_pslverr = 1'b0; wcnt++; prev_wait = 1;
      end else begin
        m_pready = 1'b1; m_pslverr = err_cfg[xn];
        obs_a.push_back(m_paddr); obs_d.push_back(m_pwdata);
        if (xn < 63) xn++;
        wcnt = 0; prev_wait = 0;
      end
      prev_a = m_paddr; prev_d = m_pwdata;
    end else begin
      m_pready = 1'b0; m_pslverr = 1'b0; prev_wait = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic pulse_trig();
    @(posedge pclk); #1 trig = 1'b1;
    @(posedge pclk); #1 trig = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge pclk); #1 clr = 1'b1;
    @(posedge pclk); #1 clr = 1'b0;
  endtask

  task automatic write_entry(input int i, input logic [31:0] a, input logic [31:0] d);
    @(posedge pclk); #1 cfg_we = 1'b1; cfg_idx = IW'(i); cfg_addr = a; cfg_data = d;
    @(posedge pclk); #1 cfg_we = 1'b0;
  endtask

  task automatic prog_entry(input int i, input logic [31:0] a, input logic [31:0] d);
    write_entry(i, a, d);
    mdl_addr[i] = a; mdl_data[i] = d;
  endtask

  // expected writes for one sequence: min(num, DEPTH) entries, cut short after an error
  task automatic model_seq(input int num_cfg, input int errpos);
    int n;
    n = (num_cfg > DEPTH) ? DEPTH : num_cfg;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(mdl_addr[i]); exp_d.push_back(mdl_data[i]);
      if (i == errpos) break;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int t;
    t = 0;
    while (done_cnt < target && t < budget) begin
      @(posedge pclk); #1; t++;
    end
    if (done_cnt < target) check("wait_done_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic compare_xfers(input string tag);
    int n;
    check({tag, "_count"}, 64'(obs_a.size()), 64'(exp_a.size()));
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 64'(obs_a[i]), 64'(exp_a[i]));
      check({tag, "_data"}, 64'(obs_d[i]), 64'(exp_d[i]));
    end
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic slave_reset();
    for (int i = 0; i < 64; i++) begin wait_cfg[i] = 0; err_cfg[i] = 0; end
    xn = 0; wcnt = 0;
  endtask

  int b0, d0, a0, ncfg, errpos, n, k, exp_busy;

  initial begin
    slave_reset();
    for (int i = 0; i < DEPTH; i++) begin mdl_addr[i] = '0; mdl_data[i] = '0; end
    #12;
    check("rst_psel", 64'(m_psel), 0);
    check("rst_penable", 64'(m_penable), 0);
    check("rst_pwrite", 64'(m_pwrite), 0);
    check("rst_paddr", 64'(m_paddr), 0);
    check("rst_pwdata", 64'(m_pwdata), 0);
    check("rst_flags", 64'({busy, done, err, ovf}), 0);
    #11 presetn = 1'b1;
    seq_en = 1'b1;

    // basic three-entry sequence, zero-wait slave
    prog_entry(0, 32'h40, 32'h1);
    prog_entry(1, 32'h44, 32'h2);
    prog_entry(2, 32'h48, 32'h3);
    prog_entry(3, $urandom, $urandom);
    cfg_num = 3;
    slave_reset(); b0 = busy_cnt; d0 = done_cnt;
    pulse_trig();
    check("t1_psel_next_edge", 64'({m_psel, m_penable, busy}), 64'(3'b101));
    check("t1_first_addr", 64'(m_paddr), 64'h40);
    model_seq(3, -1);
    wait_done(d0 + 1, 50);
    tick(2);
    check("t1_busy_cycles", 64'(busy_cnt - b0), 6);
    check("t1_done_count", 64'(done_cnt - d0), 1);
    check("t1_err", 64'(err), 0);
    compare_xfers("t1");

    // wait states then slave error on entry 1
    for (int i = 0; i < DEPTH; i++) prog_entry(i, $urandom, $urandom);
    cfg_num = 3;
    slave_reset(); wait_cfg[1] = 2; err_cfg[1] = 1;
    b0 = busy_cnt; d0 = done_cnt;
    pulse_trig();
    model_seq(3, 1);
    wait_done(d0 + 1, 50);
    tick(2);
    check("t2_err", 64'(err), 1);
    check("t2_done_count", 64'(done_cnt - d0), 1);
    check("t2_busy_cycles", 64'(busy_cnt - b0), 6);
    compare_xfers("t2");
    pulse_clr();
    check("t2_err_cleared", 64'(err), 0);

    // trigger queueing and overflow
    slave_reset(); d0 = done_cnt;
    pulse_trig();
    pulse_trig();
    model_seq(3, -1); model_seq(3, -1);
    wait_done(d0 + 1, 50);
    pulse_trig();
    pulse_trig();
    check("t3_ovf_set", 64'(ovf), 1);
    check("t3_restart_gap", 64'(gap), 1);
    model_seq(3, -1);
    wait_done(d0 + 3, 100);
    tick(3);
    check("t3_done_count", 64'(done_cnt - d0), 3);
    check("t3_err", 64'(err), 0);
    compare_xfers("t3");
    pulse_clr();
    check("t3_ovf_cleared", 64'(ovf), 0);

    // cfg_num = 0: trigger ignored
    slave_reset(); d0 = done_cnt; cfg_num = 0;
    pulse_trig();
    tick(6);
    check("t4_num0_done", 64'(done_cnt - d0), 0);
    compare_xfers("t4_num0");

    // seq_en = 0: trigger not latched
    cfg_num = 2; seq_en = 1'b0;
    pulse_trig();
    tick(4);
    seq_en = 1'b1;
    tick(6);
    check("t4_seqen_done", 64'(done_cnt - d0), 0);
    compare_xfers("t4_seqen");

    // table write while busy is dropped
    slave_reset(); d0 = done_cnt;
    pulse_trig();
    model_seq(2, -1);
    write_entry(0, $urandom, $urandom);
    wait_done(d0 + 1, 50);
    pulse_trig();
    model_seq(2, -1);
    wait_done(d0 + 2, 50);
    tick(2);
    compare_xfers("t4_we_busy");

    // cfg_num above DEPTH clamps
    slave_reset(); d0 = done_cnt; cfg_num = 7;
    pulse_trig();
    model_seq(7, -1);
    wait_done(d0 + 1, 50);
    tick(2);
    compare_xfers("t4_clamp");

    // randomized sequences: random length, wait states, error position
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) prog_entry(i, $urandom, $urandom);
      ncfg = $urandom_range(1, 7);
      errpos = $urandom_range(0, 7);
      slave_reset();
      for (int i = 0; i < DEPTH; i++) begin
        wait_cfg[i] = $urandom_range(0, 3);
        err_cfg[i] = (i == errpos);
      end
      n = (ncfg > DEPTH) ? DEPTH : ncfg;
      k = (errpos < n) ? errpos + 1 : n;
      exp_busy = 0;
      for (int i = 0; i < k; i++) exp_busy += 2 + wait_cfg[i];
      cfg_num = (IW+1)'(ncfg);
      b0 = busy_cnt; d0 = done_cnt;
      pulse_trig();
      model_seq(ncfg, errpos);
      wait_done(d0 + 1, 100);
      tick(2);
      check("rnd_busy_cycles", 64'(busy_cnt - b0), 64'(exp_busy));
      check("rnd_done_count", 64'(done_cnt - d0), 1);
      check("rnd_err", 64'(err), 64'(errpos < n));
      compare_xfers("rnd");
      pulse_clr();
    end

    // asynchronous reset while in ACCESS
    slave_reset(); wait_cfg[0] = 1000; cfg_num = 2;
    pulse_trig();
    tick(2);
    check("t5_in_access", 64'({m_psel, m_penable}), 64'(2'b11));
    #2 presetn = 1'b0;
    #1;
    check("t5_rst_apb", 64'({m_psel, m_penable, m_pwrite}), 0);
    check("t5_rst_addr_data", {m_paddr, m_pwdata}, 0);
    check("t5_rst_flags", 64'({busy, done, err, ovf}), 0);
    tick(2);
    #3 presetn = 1'b1;
    slave_reset();
    for (int i = 0; i < DEPTH; i++) begin mdl_addr[i] = '0; mdl_data[i] = '0; end
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    d0 = done_cnt;
    pulse_trig();
    model_seq(2, -1);
    wait_done(d0 + 1, 50);
    tick(2);
    compare_xfers("t5_table_zeroed");

`ifdef APB_TRIG_SEQ_TIMEOUT_EN
    // watchdog: slave never answers
    slave_reset(); wait_cfg[0] = 1000; cfg_num = 2;
    d0 = done_cnt; a0 = acc_cnt;
    pulse_trig();
    wait_done(d0 + 1, 60);
    tick(2);
    check("t6_access_cycles", 64'(acc_cnt - a0), 16);
    check("t6_err", 64'(err), 1);
    check("t6_done_count", 64'(done_cnt - d0), 1);
    check("t6_psel_dropped", 64'({m_psel, m_penable}), 0);
    compare_xfers("t6");
    pulse_clr();
    slave_reset();
`endif

    check("hold_stable_in_wait", 64'(hold_viol), 0);
    check("pwrite_during_psel", 64'(pwrite_viol), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
